// File: rtl/alu_issue_stage.sv
// Issue/writeback wrapper around the combinational 16-bit ALU: decode, 16-entry register file,
// operand staging, result and flag capture. One instruction in flight, four cycles each.
module alu_issue_stage #(
    parameter int WIDTH    = 16,
    parameter int REG_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [15:0]         instr,
    output logic                instr_ready,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [3:0]          alu_opcode,
    output logic [3:0]          alu_shift_bits,
    output logic                alu_execute,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic [3:0]          alu_flags,
    output logic [3:0]          flags_q,
    output logic                illegal_op,
    input  logic [REG_ADDR-1:0] dbg_addr,
    output logic [WIDTH-1:0]    dbg_data
);

    localparam int DEPTH = 2 ** REG_ADDR;

    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_NOP = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         instr_q, instr_d;
    logic [WIDTH-1:0]    regs_q [DEPTH];
    logic [WIDTH-1:0]    regs_d [DEPTH];
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [3:0]          alu_opcode_q, alu_opcode_d;
    logic [3:0]          alu_shift_q, alu_shift_d;
    logic                exec_q, exec_d;
    logic                illegal_q, illegal_d;
    logic [3:0]          flags_d;

    logic [3:0]          op;
    logic [REG_ADDR-1:0] rd, rs, rt;
    logic                is_alu, is_shift, is_cmp, is_ldi, is_illegal;
    logic [WIDTH-1:0]    rs_val, rt_val, imm_val;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[8 +: REG_ADDR];
    assign rs  = instr_q[4 +: REG_ADDR];
    assign rt  = instr_q[0 +: REG_ADDR];

    assign is_alu     = (op <= OP_ROR);
    assign is_shift   = (op >= OP_LSL) && (op <= OP_ROR);
    assign is_cmp     = (op == OP_CMP);
    assign is_ldi     = (op == OP_LDI);
    assign is_illegal = (op > OP_LDI) && (op < OP_NOP);

    // r0 is hard-wired to zero on every read path
    assign rs_val   = (rs == '0) ? '0 : regs_q[rs];
    assign rt_val   = (rt == '0) ? '0 : regs_q[rt];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    assign imm_val  = {{(WIDTH-8){1'b0}}, instr_q[7:0]};

    assign instr_ready    = (state_q == S_IDLE);
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_opcode     = alu_opcode_q;
    assign alu_shift_bits = alu_shift_q;
    assign alu_execute    = exec_q;
    assign illegal_op     = illegal_q;

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_shift_d  = alu_shift_q;
        exec_d       = 1'b0;
        illegal_d    = 1'b0;
        flags_d      = flags_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                alu_a_d = rs_val;
                alu_b_d = rt_val;
                if (is_alu)
                    alu_opcode_d = op;
                else if (is_cmp)
                    alu_opcode_d = OP_SUB;
                else
                    alu_opcode_d = 4'd0;
                alu_shift_d = is_shift ? instr_q[3:0] : 4'd0;
                exec_d      = 1'b1;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                exec_d    = 1'b1;
                // registered so the pulse lines up with the WB cycle
                illegal_d = is_illegal;
                state_d   = S_WB;
            end
            S_WB: begin
                if (rd != '0) begin
                    if (is_alu)
                        regs_d[rd] = alu_result;
                    else if (is_ldi)
                        regs_d[rd] = imm_val;
                end
                if (is_alu || is_cmp)
                    flags_d = alu_flags;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            regs_q       <= '{default: '0};
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_shift_q  <= '0;
            exec_q       <= 1'b0;
            illegal_q    <= 1'b0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            regs_q       <= regs_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_shift_q  <= alu_shift_d;
            exec_q       <= exec_d;
            illegal_q    <= illegal_d;
            flags_q      <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a small behavioural ALU closing the loop.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode, alu_shift_bits;
    logic        alu_execute;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  flags_q;
    logic        illegal_op;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    alu_issue_stage #(.WIDTH(16), .REG_ADDR(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_shift_bits(alu_shift_bits),
        .alu_execute(alu_execute), .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q), .illegal_op(illegal_op),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stand-in; flags = {res[15], res==0, res[0], parity(res)}
    logic [31:0] rot;
    always_comb begin
        rot = {alu_a, alu_a} >> alu_shift_bits;
        case (alu_opcode)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a * alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a & alu_b;
            4'd5:    alu_result = alu_a ^ alu_b;
            4'd6:    alu_result = alu_a << alu_shift_bits;
            4'd7:    alu_result = alu_a >> alu_shift_bits;
            4'd8:    alu_result = rot[15:0];
            default: alu_result = 16'h0000;
        endcase
        alu_flags = {alu_result[15], (alu_result == 16'h0000), alu_result[0], ^alu_result};
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [3:0]  sh;
        bit          chk_b;
        logic [3:0]  chk_addr;
        logic [15:0] chk_val;
        logic [3:0]  flags;
        bit          illegal;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    bit    mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] op, input logic [3:0] sh, input bit chk_b,
                                 input logic [3:0] ca, input logic [15:0] cv,
                                 input logic [3:0] fl, input bit ill);
        item_t t;
        t.instr = i; t.a = a; t.b = b; t.op = op; t.sh = sh; t.chk_b = chk_b;
        t.chk_addr = ca; t.chk_val = cv; t.flags = fl; t.illegal = ill;
        return t;
    endfunction

    // Presents an instruction, waits for acceptance, returns cycle number of the accepting edge
    task automatic issue(input item_t it, input bit push, input bit hold, output int acc);
        int n = 0;
        @(negedge clk);
        instr       = it.instr;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("accept_timeout", 0, 1);
        acc = cyc;
        if (push) sb_q.push_back(it);
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("idle_timeout", 0, 1);
    endtask

    // Monitor: first EXEC cycle pops the expected record, then checks WB and the following IDLE cycle
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && alu_execute) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_exec", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("exec_alu_a", alu_a, e.a);
                    if (e.chk_b) check("exec_alu_b", alu_b, e.b);
                    check("exec_opcode", alu_opcode, e.op);
                    check("exec_shift", alu_shift_bits, e.sh);
                    check("exec_illegal_low", illegal_op, 0);
                    check("exec_ready_low", instr_ready, 0);
                    @(negedge clk);
                    check("wb_execute", alu_execute, 1);
                    check("wb_alu_a_held", alu_a, e.a);
                    check("wb_opcode_held", alu_opcode, e.op);
                    check("wb_illegal", illegal_op, e.illegal);
                    dbg_addr = e.chk_addr;
                    @(negedge clk);
                    check("idle_execute_low", alu_execute, 0);
                    check("idle_illegal_low", illegal_op, 0);
                    check("idle_ready", instr_ready, 1);
                    check("wb_reg_value", dbg_data, e.chk_val);
                    check("wb_flags", flags_q, e.flags);
                end
            end
        end
    end

    initial begin
        item_t seq[$];
        int acc, acc_prev, n;

        // reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_execute", alu_execute, 0);
        check("rst_flags", flags_q, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_alu_a", alu_a, 0);

        // reset in the middle of ADD r3,r1,r2: nothing committed
        issue(mk(16'hA105, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, acc);
        wait_idle();
        issue(mk(16'hA203, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, acc);
        wait_idle();
        dbg_addr = 4'd1;
        @(negedge clk);
        check("pre_rst_r1", dbg_data, 16'h0005);
        issue(mk(16'h0312, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, acc);
        n = 0;
        @(negedge clk);
        while (!alu_execute && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_exec", alu_execute, 1);
        check("pre_rst_alu_a", alu_a, 16'h0005);
        rst = 1'b1;
        @(negedge clk);
        check("in_rst_execute", alu_execute, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", instr_ready, 1);
        check("post_rst_execute", alu_execute, 0);
        check("post_rst_flags", flags_q, 0);
        check("post_rst_opcode", alu_opcode, 0);
        dbg_addr = 4'd3;
        #1 check("post_rst_r3", dbg_data, 16'h0000);
        dbg_addr = 4'd1;
        #1 check("post_rst_r1", dbg_data, 16'h0000);

        // scoreboarded sequence; register file starts all-zero
        mon_en = 1'b1;
        seq.push_back(mk(16'hA105, 16'h0000, 16'h0000, 4'd0, 4'd0, 1, 4'd1,  16'h0005, 4'b0000, 0));
        seq.push_back(mk(16'hA203, 16'h0000, 16'h0000, 4'd0, 4'd0, 1, 4'd2,  16'h0003, 4'b0000, 0));
        seq.push_back(mk(16'h0312, 16'h0005, 16'h0003, 4'd0, 4'd0, 1, 4'd3,  16'h0008, 4'b0001, 0));
        seq.push_back(mk(16'hA181, 16'h0000, 16'h0005, 4'd0, 4'd0, 1, 4'd1,  16'h0081, 4'b0001, 0));
        seq.push_back(mk(16'h8414, 16'h0081, 16'h0000, 4'd8, 4'd4, 0, 4'd4,  16'h1008, 4'b0000, 0));
        seq.push_back(mk(16'hA507, 16'h0000, 16'h0000, 4'd0, 4'd0, 1, 4'd5,  16'h0007, 4'b0000, 0));
        seq.push_back(mk(16'hA607, 16'h0000, 16'h0000, 4'd0, 4'd0, 1, 4'd6,  16'h0007, 4'b0000, 0));
        seq.push_back(mk(16'h9756, 16'h0007, 16'h0007, 4'd1, 4'd0, 1, 4'd7,  16'h0000, 4'b0100, 0));
        seq.push_back(mk(16'h1851, 16'h0007, 16'h0081, 4'd1, 4'd0, 1, 4'd8,  16'hFF86, 4'b1001, 0));
        seq.push_back(mk(16'hC912, 16'h0081, 16'h0003, 4'd0, 4'd0, 1, 4'd9,  16'h0000, 4'b1001, 1));
        seq.push_back(mk(16'hA0FF, 16'h0000, 16'h0000, 4'd0, 4'd0, 1, 4'd0,  16'h0000, 4'b1001, 0));
        foreach (seq[i]) issue(seq[i], 1, 0, acc);

        // instr_valid held high: acceptances every 4 cycles, instr swapped while not ready
        issue(mk(16'h5A41, 16'h1008, 16'h0081, 4'd5, 4'd0, 1, 4'd10, 16'h1089, 4'b0010, 0), 1, 1, acc_prev);
        issue(mk(16'h2B52, 16'h0007, 16'h0003, 4'd2, 4'd0, 1, 4'd11, 16'h0015, 4'b0011, 0), 1, 1, acc);
        check("spacing_1", acc - acc_prev, 4);
        acc_prev = acc;
        issue(mk(16'h6C23, 16'h0003, 16'h0000, 4'd6, 4'd3, 0, 4'd12, 16'h0018, 4'b0000, 0), 1, 0, acc);
        check("spacing_2", acc - acc_prev, 4);

        issue(mk(16'hF123, 16'h0003, 16'h0008, 4'd0, 4'd0, 1, 4'd12, 16'h0018, 4'b0000, 0), 1, 0, acc);
        issue(mk(16'h3D12, 16'h0081, 16'h0003, 4'd3, 4'd0, 1, 4'd13, 16'h0083, 4'b0011, 0), 1, 0, acc);
        issue(mk(16'h7E4C, 16'h1008, 16'h0000, 4'd7, 4'd12, 0, 4'd14, 16'h0001, 4'b0011, 0), 1, 0, acc);

        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb_q.size(), 0);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
